// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared byte width, arbiter FSM state encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Round-robin successor of idx among n requesters.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin pick: first asserted req at or
//               after ptr, wrapping from NREQ-1 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    int   w_cand;
    logic w_found;

    always_comb begin
        valid   = |req;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = (int'(ptr) + k) % NREQ;
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                idx     = ID_W'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART transmitter among NREQ
//               requesters. Optional WAIT watchdog: UART_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*BYTE_W-1:0]   req_data,
    output logic [NREQ-1:0]          ack,
    output logic                     tx_start,
    output logic [BYTE_W-1:0]        tx_data,
    input  logic                     tx_done,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int c_ID_W = $clog2(NREQ);

    state_t            r_state;
    logic [c_ID_W-1:0] r_ptr;
    logic              r_gap;
    logic              w_valid;
    logic [c_ID_W-1:0] w_idx;
    logic [c_ID_W-1:0] w_next_ptr;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_expire;

    // Expiry on the TIMEOUT_CYCLES-th WAIT cycle without tx_done.
    assign w_expire = (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign timeout_err      = 1'b0;
`endif

    assign w_next_ptr = c_ID_W'(wrap_inc(int'(grant_id), NREQ));

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (c_ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_valid),
        .idx   (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gap       <= 1'b0;
            grant_id    <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            ack         <= '0;
            busy        <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt       <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            tx_start    <= 1'b0;
            ack         <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    // r_gap holds off a grant for the cycle right after a
                    // completion so ack and the next tx_start never touch.
                    r_gap <= 1'b0;
                    if (w_valid && !r_gap) begin
                        grant_id <= w_idx;
                        tx_data  <= req_data[w_idx*BYTE_W +: BYTE_W];
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_state <= WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                WAIT: begin
                    if (tx_done) begin
                        ack[grant_id] <= 1'b1;
                        r_ptr         <= w_next_ptr;
                        r_gap         <= 1'b1;
                        busy          <= 1'b0;
                        r_state       <= IDLE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (w_expire) begin
                        timeout_err <= 1'b1;
                        r_ptr       <= w_next_ptr;
                        r_gap       <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter (NREQ=4, watchdog 50).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int T = 50;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic [1:0]     grant_id;
    logic           busy;
    logic           timeout_err;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;

    uart_tx_arbiter #(
        .NREQ           (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Winner = asserted requester with the smallest forward distance from p.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        int best  = 0;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (r[i] && ((i - p + N) % N) < bestd) begin
                bestd = (i - p + N) % N;
                best  = i;
            end
        end
        return best;
    endfunction

    // One full handshake; called while idle with req already driven.
    task automatic transfer(input int dly, input bit drop, input bit early,
                            input logic [N*8-1:0] new_data, output int obs_id);
        int         id;
        int         n;
        logic [7:0] exp_data;
        logic       ack_seen;
        logic       to_seen;
        id       = model_pick(req, m_ptr);
        exp_data = req_data[id*8 +: 8];
        n        = 0;
        while (tx_start !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        obs_id = int'(grant_id);
        check("start_latency", n, 1);
        check("grant_id", grant_id, id);
        check("tx_data_grant", tx_data, exp_data);
        check("busy_launch", busy, 1);
        if (drop) req = '0;
        req_data = new_data;
        tx_done  = early;
        tick();
        tx_done  = 1'b0;
        check("tx_start_one_cycle", tx_start, 0);
        check("no_ack_launch", ack, 0);
        check("busy_wait", busy, 1);
        ack_seen = 1'b0;
        to_seen  = 1'b0;
        for (int i = 0; i < dly - 2; i++) begin
            tick();
            ack_seen = ack_seen | (|ack);
            to_seen  = to_seen | timeout_err;
        end
        check("no_early_ack", ack_seen, 0);
        check("no_timeout_wait", to_seen, 0);
        check("tx_data_hold", tx_data, exp_data);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("ack", ack, 32'd1 << id);
        check("busy_done", busy, 0);
        check("no_timeout_done", timeout_err, 0);
        m_ptr = (id + 1) % N;
        tick();
        check("ack_one_cycle", ack, 0);
        check("idle_gap", tx_start, 0);
    endtask

    initial begin
        int         obs;
        int         exp_id;
        int         n;
        logic       seen;
        logic [31:0] nd;

        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        tx_done  = 1'b0;
        repeat (3) tick();
        check("rst_ack", ack, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_err, 0);
        rst = 1'b0;

        // Fairness: all requesting, grants walk 0,1,2,3,0,1,2,3.
        req      = 4'b1111;
        req_data = $urandom;
        for (int k = 0; k < 8; k++) begin
            transfer($urandom_range(2, 8), 1'b0, 1'b0, $urandom, obs);
            check("fair_seq", obs, k % 4);
        end

        // Single request from requester 1, completion 40 cycles after launch.
        req      = 4'b0010;
        req_data = $urandom;
        req_data[15:8] = 8'hA5;
        transfer(40, 1'b1, 1'b0, req_data, obs);
        check("single_grant", obs, 1);
        check("single_data", tx_data, 8'hA5);

        // Reset while in WAIT abandons the transfer.
        req      = 4'b1111;
        req_data = $urandom;
        tick();
        check("rstw_start", tx_start, 1);
        repeat (3) tick();
        check("rstw_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        check("rstw_busy", busy, 0);
        check("rstw_ack", ack, 0);
        check("rstw_grant", grant_id, 0);
        check("rstw_tx_data", tx_data, 0);
        check("rstw_timeout", timeout_err, 0);
        m_ptr   = 0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("rstw_ack_after", ack, 0);
        check("rstw_idle", busy, 0);
        req = 4'b1010;
        transfer(5, 1'b1, 1'b0, $urandom, obs);
        check("rstw_ptr_zero", obs, 1);
        req = 4'b1000;
        transfer(5, 1'b1, 1'b0, $urandom, obs);
        check("rstw_next3", obs, 3);

        // Data changing after the grant must not reach tx_data.
        req      = 4'b0001;
        req_data = $urandom;
        req_data[7:0] = 8'h11;
        nd       = req_data;
        nd[7:0]  = 8'h22;
        transfer(10, 1'b0, 1'b0, nd, obs);
        check("data_hold_11", tx_data, 8'h11);

        // tx_done coincident with tx_start is ignored.
        req = 4'b0100;
        transfer(6, 1'b1, 1'b1, $urandom, obs);
        check("early_done_grant", obs, 2);

        for (int k = 0; k < 12; k++) begin
            req      = 4'($urandom_range(1, 15));
            req_data = $urandom;
            transfer($urandom_range(2, 20), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom, obs);
        end

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog expiry: no tx_done at all.
        req      = 4'b1111;
        req_data = $urandom;
        exp_id   = model_pick(req, m_ptr);
        tick();
        check("to_start", tx_start, 1);
        check("to_grant", grant_id, exp_id);
        n    = 0;
        seen = 1'b0;
        while (timeout_err !== 1'b1 && n < 4 * T) begin
            tick();
            n++;
            seen = seen | (|ack);
        end
        check("timeout_latency", n, T + 1);
        check("timeout_no_ack", seen, 0);
        check("timeout_busy", busy, 0);
        m_ptr = (exp_id + 1) % N;
        tick();
        check("timeout_one_cycle", timeout_err, 0);
        check("timeout_gap", tx_start, 0);
        transfer(5, 1'b0, 1'b0, $urandom, obs);
        check("timeout_next_idx", obs, (exp_id + 1) % N);
        // tx_done on the expiry cycle completes normally.
        transfer(T + 1, 1'b0, 1'b0, $urandom, obs);
`else
        // No watchdog: a long WAIT still completes normally.
        req = 4'b0001;
        transfer(4 * T, 1'b1, 1'b0, $urandom, obs);
        check("long_wait_grant", obs, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one UART transmitter, range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000: watchdog limit in clk cycles, used only when the macro is defined.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its posedge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req, input, NREQ bits: per-requester transmit request, level.
REQ-006 SHALL have port req_data, input, NREQ*8 bits: byte i is bits [8i+7:8i].
REQ-007 SHALL have port ack, output, NREQ bits: one-cycle pulse when requester i's byte has completed.
REQ-008 SHALL have port tx_start, output, 1 bit: one-cycle launch pulse to the transmitter.
REQ-009 SHALL have port tx_data, output, 8 bits: byte presented to the transmitter.
REQ-010 SHALL have port tx_done, input, 1 bit: transmitter completion pulse.
REQ-011 SHALL have port grant_id, output, clog2(NREQ) bits: index of the current or last granted requester.
REQ-012 SHALL have port busy, output, 1 bit: high in LAUNCH and WAIT.
REQ-013 SHALL have port timeout_err, output, 1 bit: one-cycle pulse on watchdog expiry.

Function
REQ-014 SHALL implement the FSM states IDLE, LAUNCH and WAIT.
REQ-015 SHALL, in IDLE with req!=0, select the winner by round-robin starting at the index held in ptr, register grant_id=winner and tx_data=req_data[winner], and go to LAUNCH.
REQ-016 SHALL, in IDLE with req==0, stay in IDLE with all outputs unchanged.
REQ-017 SHALL, in LAUNCH, drive tx_start=1 for exactly one cycle and go to WAIT; latency is req sampled at cycle n, tx_start high at cycle n+1.
REQ-018 SHALL ignore tx_done in IDLE and LAUNCH, including tx_done coincident with tx_start.
REQ-019 SHALL, in WAIT on tx_done=1, pulse ack[grant_id] on the next cycle, set ptr=(grant_id+1) mod NREQ and return to IDLE.
REQ-020 SHALL sample req_data only in IDLE; changes to req_data after the grant SHALL NOT alter tx_data.
REQ-021 SHALL, when the granted requester drops req before completion, still complete the transfer and still pulse ack.
REQ-022 SHALL enforce at least one IDLE cycle between ack and the next tx_start.
REQ-023 SHALL give a single requester holding req continuously back-to-back grants, one byte per handshake.
REQ-024 SHALL, when all requesters are active, grant in index order ptr, ptr+1, ... wrapping from NREQ-1 to 0.
REQ-025 SHALL hold tx_data stable from LAUNCH until the next grant.

Reset
REQ-026 SHALL, on rst=1 at a posedge, force state=IDLE, ptr=0, grant_id=0, tx_data=0, tx_start=0, ack=0, busy=0, timeout_err=0 and the watchdog count=0.
REQ-027 SHALL, on rst asserted mid-transfer (LAUNCH or WAIT), abandon the transfer with no ack and no timeout_err, and keep ack=0 on the cycle after reset.

Configuration
REQ-028 SHALL, with UART_ARB_TIMEOUT_EN defined, count cycles in WAIT and, when the count reaches TIMEOUT_CYCLES without tx_done, pulse timeout_err, give no ack, advance ptr as in REQ-019 and return to IDLE.
REQ-029 SHALL, without UART_ARB_TIMEOUT_EN, wait indefinitely in WAIT, tie timeout_err to 0 and contain no watchdog counter.
REQ-030 SHALL treat tx_done arriving on the same cycle as watchdog expiry as a normal completion: ack, no timeout_err.

Structure
REQ-031 SHALL take the FSM state enum (IDLE/LAUNCH/WAIT) and the BYTE_W=8 constant from the shared package uart_pkg.
REQ-032 SHALL place the round-robin selection in sub-module rr_pick: combinational, inputs req and ptr, outputs valid and idx.

Verification
REQ-033 SHALL cover a single request: req=4'b0010, byte1=8'hA5, tx_done 40 cycles after tx_start -> tx_start at n+1, tx_data=8'hA5, grant_id=1, ack=4'b0010 one cycle after tx_done.
REQ-034 SHALL cover fairness: req=4'b1111 held for 8 transfers -> grant_id sequence 0,1,2,3,0,1,2,3.
REQ-035 SHALL cover a data change: req_data[0] changed from 8'h11 to 8'h22 after grant -> tx_data stays 8'h11.
REQ-036 SHALL cover reset in WAIT: rst pulsed in WAIT -> busy=0, ack=0, ptr=0; next req=4'b1000 gets grant_id=3.
REQ-037 SHALL cover timeout, macro on with TIMEOUT_CYCLES=50: no tx_done -> timeout_err pulse 50 cycles into WAIT, no ack, next grant goes to the next index.
REQ-038 SHALL cover an early tx_done coincident with tx_start -> ignored; FSM stays in WAIT until a later tx_done.
